// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, stall, flush and forwarding control for a 5-stage pipeline.
//
// Ports
//   clk                   clock; all state updates on posedge
//   r                     synchronous active-low reset
//   id_rs, id_rt          source registers of the instruction in ID
//   ex_rs, ex_rt          source registers of the instruction in EX
//   ex_regwrite, ex_memread, ex_rd   EX-stage destination controls
//   mem_regwrite, mem_rd  EX/MEM destination
//   wb_regwrite, wb_rd    MEM/WB destination
//   br_taken              branch/jump resolved taken in EX
//   mem_req, mem_ack      data-memory access in MEM / completes this cycle
//   pc_en, ifid_en, idex_en, exmem_en   stage-register load enables
//   ifid_clr, idex_clr, memwb_clr       synchronous bubble-insert clears
//   fwd_a, fwd_b          EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   state                 FSM state (RUN=00, LDSTALL=01, MWAIT=10, FLUSH=11)
//   stall_cnt             saturating count of cycles with pc_en=0
//
// Configuration
//   PIPELINE_CTRL_FORWARD_EN defined: forwarding active, only load-use stalls.
//   Undefined (default): no forwarding, stall on any RAW match in EX/MEM/WB.

module pipeline_ctrl (
  input  logic        clk,
  input  logic        r,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_rd,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic        br_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        ifid_clr,
  output logic        idex_clr,
  output logic        memwb_clr,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StLdStall = 2'b01,
    StMwait   = 2'b10,
    StFlush   = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        hazard;
  logic [1:0]  fwd_a_raw, fwd_b_raw;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic dep(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

`ifdef PIPELINE_CTRL_FORWARD_EN
  // Forwarding covers everything except a load result needed by the very next instruction.
  assign hazard = ex_memread && (dep(ex_regwrite, ex_rd, id_rs) || dep(ex_regwrite, ex_rd, id_rt));

  // EX/MEM is the younger result, so it takes precedence over MEM/WB.
  always_comb begin
    fwd_a_raw = 2'b00;
    fwd_b_raw = 2'b00;
    if (dep(mem_regwrite, mem_rd, ex_rs))     fwd_a_raw = 2'b10;
    else if (dep(wb_regwrite, wb_rd, ex_rs))  fwd_a_raw = 2'b01;
    if (dep(mem_regwrite, mem_rd, ex_rt))     fwd_b_raw = 2'b10;
    else if (dep(wb_regwrite, wb_rd, ex_rt))  fwd_b_raw = 2'b01;
  end
`else
  // Without forwarding, ID must wait until every in-flight producer has written back.
  assign hazard = dep(ex_regwrite, ex_rd, id_rs)   || dep(ex_regwrite, ex_rd, id_rt)  ||
                  dep(mem_regwrite, mem_rd, id_rs) || dep(mem_regwrite, mem_rd, id_rt) ||
                  dep(wb_regwrite, wb_rd, id_rs)   || dep(wb_regwrite, wb_rd, id_rt);
  assign fwd_a_raw = 2'b00;
  assign fwd_b_raw = 2'b00;
`endif

  always_comb begin
    state_d   = StRun;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    exmem_en  = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    memwb_clr = 1'b0;
    fwd_a     = fwd_a_raw;
    fwd_b     = fwd_b_raw;

    if (!r) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      memwb_clr = 1'b1;
      fwd_a     = 2'b00;
      fwd_b     = 2'b00;
    end else if ((state_q == StMwait) ? !mem_ack : (mem_req && !mem_ack)) begin
      // Freeze everything up to MEM and drain a bubble into WB.
      state_d   = StMwait;
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_clr = 1'b1;
    end else if (state_q == StMwait) begin
      state_d = StRun;
    end else if (br_taken && (state_q != StFlush)) begin
      state_d  = StFlush;
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if (hazard) begin
      state_d  = StLdStall;
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_clr = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!pc_en && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      state_q <= StRun;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        r;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic        ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
  logic        br_taken, mem_req, mem_ack;
  logic        pc_en, ifid_en, idex_en, exmem_en;
  logic        ifid_clr, idex_clr, memwb_clr;
  logic [1:0]  fwd_a, fwd_b, state;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .r(r), .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .br_taken(br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_clr(ifid_clr), .idex_clr(idex_clr), .memwb_clr(memwb_clr),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1-2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r = 1'b1;
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0; wb_regwrite = 0;
    br_taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  function automatic logic [3:0] ens();
    return {pc_en, ifid_en, idex_en, exmem_en};
  endfunction

  function automatic logic [2:0] clrs();
    return {ifid_clr, idex_clr, memwb_clr};
  endfunction

  initial begin
    idle();
    // Reset with conflicting requests present.
    r = 1'b0; br_taken = 1'b1; mem_req = 1'b1;
    tick(); tick(); #1;
    chk("rst_state", state, 2'b00);
    chk("rst_cnt", stall_cnt, 16'd0);
    chk("rst_ens", ens(), 4'b0000);
    chk("rst_clrs", clrs(), 3'b111);
    chk("rst_fwd", {fwd_a, fwd_b}, 4'b0000);

    // Plain advance.
    idle(); #1;
    chk("adv_ens", ens(), 4'b1111);
    chk("adv_clrs", clrs(), 3'b000);
    tick();
    chk("adv_state", state, 2'b00);

    // Load-use hazard.
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rs = 5; #1;
    chk("lu_ens", ens(), 4'b0011);
    chk("lu_clrs", clrs(), 3'b010);
    tick();
    chk("lu_state", state, 2'b01);
    chk("lu_cnt", stall_cnt, 16'd1);
    idle(); #1;
    chk("lu_release_ens", ens(), 4'b1111);
    tick();
    chk("lu_release_state", state, 2'b00);

    // Destination r0 never matches.
    ex_memread = 1; ex_regwrite = 1; ex_rd = 0; id_rs = 0; #1;
    chk("r0_pc_en", pc_en, 1'b1);
    tick();
    chk("r0_state", state, 2'b00);
    chk("r0_cnt", stall_cnt, 16'd1);

    // Memory wait with branch pending throughout: branch must not flush.
    idle(); mem_req = 1; br_taken = 1; #1;
    chk("mw_ens", ens(), 4'b0000);
    chk("mw_clrs", clrs(), 3'b001);
    tick();
    chk("mw_state1", state, 2'b10);
    chk("mw_clrs2", clrs(), 3'b001);
    tick(); tick();
    chk("mw_state3", state, 2'b10);
    chk("mw_cnt", stall_cnt, 16'd4);
    mem_ack = 1; #1;
    chk("mw_ack_ens", ens(), 4'b1111);
    chk("mw_ack_clrs", clrs(), 3'b000);
    tick();
    chk("mw_ack_state", state, 2'b00);
    chk("mw_ack_cnt", stall_cnt, 16'd4);

    // Branch beats a simultaneous load-use hazard; FLUSH ignores br_taken.
    idle(); br_taken = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 9; id_rt = 9; #1;
    chk("br_ens", ens(), 4'b1111);
    chk("br_clrs", clrs(), 3'b110);
    tick();
    chk("br_state", state, 2'b11);
    idle(); br_taken = 1; #1;
    chk("fl_clrs", clrs(), 3'b000);
    tick();
    chk("fl_state", state, 2'b00);

    // Forwarding priority and the no-forwarding stall.
    exp_cnt = 16'd4;
    idle(); mem_regwrite = 1; mem_rd = 7; wb_regwrite = 1; wb_rd = 7; ex_rs = 7; ex_rt = 3; #1;
`ifdef PIPELINE_CTRL_FORWARD_EN
    chk("fwd_both_a", fwd_a, 2'b10);
    chk("fwd_both_b", fwd_b, 2'b00);
    mem_regwrite = 0; #1;
    chk("fwd_wb_a", fwd_a, 2'b01);
`else
    chk("fwd_both_a", fwd_a, 2'b00);
    chk("fwd_both_b", fwd_b, 2'b00);
    mem_regwrite = 0; #1;
    chk("fwd_wb_a", fwd_a, 2'b00);
`endif
    id_rs = 7; #1;
`ifdef PIPELINE_CTRL_FORWARD_EN
    chk("raw_pc_en", pc_en, 1'b1);
    tick();
    chk("raw_state", state, 2'b00);
`else
    chk("raw_pc_en", pc_en, 1'b0);
    tick(); exp_cnt++;
    chk("raw_state", state, 2'b01);
    chk("raw_hold_pc_en", pc_en, 1'b0);
    tick(); exp_cnt++;
    chk("raw_hold_state", state, 2'b01);
`endif
    wb_regwrite = 0; #1;
    chk("raw_clear_pc_en", pc_en, 1'b1);
    tick();
    chk("raw_clear_state", state, 2'b00);
    chk("raw_cnt", stall_cnt, exp_cnt);

    // Reset mid-MWAIT aborts; first cycle after reset is RUN.
    idle(); mem_req = 1; tick();
    chk("rm_state", state, 2'b10);
    r = 0; #1;
    chk("rm_ens", ens(), 4'b0000);
    chk("rm_clrs", clrs(), 3'b111);
    tick();
    chk("rm_state0", state, 2'b00);
    chk("rm_cnt0", stall_cnt, 16'd0);
    idle(); #1;
    chk("rm_run_ens", ens(), 4'b1111);
    tick();
    chk("rm_run_state", state, 2'b00);

    // Saturation under a long memory stall.
    mem_req = 1;
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", stall_cnt, 16'hFFFE);
    tick();
    chk("sat_ffff", stall_cnt, 16'hFFFF);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold", stall_cnt, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
